// File: rtl/equiv_stim_checker_if.sv
// Stimulus/response bundle between the equivalence checker (master) and the two DUTs (slave side).
interface equiv_stim_checker_if #(
  parameter int unsigned NIN = 4
) ();
  logic [NIN-1:0] stim;
  logic           resp_a;
  logic           resp_b;

  modport master (output stim, input resp_a, input resp_b);
  modport slave  (input stim, output resp_a, output resp_b);
endinterface

// File: rtl/equiv_stim_checker.sv
// Exhaustive stimulus driver and miter: walks all NIN-bit patterns and compares two DUT outputs.
// Optional feature macro EQV_STOP_FIRST_EN ends a run on the first mismatching pattern.
module equiv_stim_checker #(
  parameter int unsigned NIN   = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  equiv_stim_checker_if.master dut_if,
  output logic                 busy,
  output logic                 done,
  output logic                 equiv,
  output logic [CNT_W-1:0]     mism_cnt,
  output logic                 first_valid,
  output logic [NIN-1:0]       first_mism
);

  localparam logic [NIN-1:0]   STIM_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NIN-1:0]   stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             equiv_q, equiv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic [NIN-1:0]   fm_q, fm_d;

  logic mism;
  logic last_pat;
  logic stop_hit;

  assign mism     = dut_if.resp_a ^ dut_if.resp_b;
  assign last_pat = (stim_q == STIM_MAX);

`ifdef EQV_STOP_FIRST_EN
  assign stop_hit = mism;
`else
  assign stop_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (last_pat || stop_hit) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values, registered below
  always_comb begin
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    equiv_d = equiv_q;
    cnt_d   = cnt_q;
    fv_d    = fv_q;
    fm_d    = fm_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          stim_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          equiv_d = 1'b0;
          cnt_d   = '0;
          fv_d    = 1'b0;
          fm_d    = '0;
        end
      end
      ST_RUN: begin
        if (mism) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            fm_d = stim_q;
          end
        end
        // stim is frozen on the final (or failing) pattern rather than wrapping
        if (state_d == ST_DONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equiv_d = !(fv_q || mism);
        end else begin
          stim_d = stim_q + NIN'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equiv_q <= 1'b0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fm_q    <= '0;
    end else begin
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equiv_q <= equiv_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fm_q    <= fm_d;
    end
  end

  assign dut_if.stim = stim_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign equiv       = equiv_q;
  assign mism_cnt    = cnt_q;
  assign first_valid = fv_q;
  assign first_mism  = fm_q;

endmodule

// File: tb/tb_equiv_stim_checker.sv
// Bench for equiv_stim_checker: truth-table DUTs, table vectors, corner sequences and random runs.
module tb_equiv_stim_checker;
  localparam int unsigned NIN = 4;
  localparam logic [15:0] EQ_TT     = 16'h9009;  // (x1==y1)&(x2==y2)
  localparam logic [15:0] FAULTY_TT = 16'hA00A;  // ~(x1^y1)&y2

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] ta = 16'h0;
  logic [15:0] tb_t = 16'h0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  equiv_stim_checker_if #(.NIN(NIN)) if5 ();
  equiv_stim_checker_if #(.NIN(NIN)) if2 ();
  assign if5.resp_a = ta[if5.stim];
  assign if5.resp_b = tb_t[if5.stim];
  assign if2.resp_a = ta[if2.stim];
  assign if2.resp_b = tb_t[if2.stim];

  logic       busy5, done5, equiv5, fv5;
  logic [4:0] cnt5;
  logic [3:0] fm5;
  logic       busy2, done2, equiv2, fv2;
  logic [1:0] cnt2;
  logic [3:0] fm2;

  equiv_stim_checker #(.NIN(NIN), .CNT_W(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .dut_if(if5.master),
    .busy(busy5), .done(done5), .equiv(equiv5), .mism_cnt(cnt5),
    .first_valid(fv5), .first_mism(fm5)
  );

  equiv_stim_checker #(.NIN(NIN), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .dut_if(if2.master),
    .busy(busy2), .done(done2), .equiv(equiv2), .mism_cnt(cnt2),
    .first_valid(fv2), .first_mism(fm2)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          eq;
    int          cnt5;
    int          cnt2;
    int          fm;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // poke >= 0: pulse start at that cycle; poke < 0: leave start untouched
  task automatic wait_done(input int poke, output int n);
    n = 0;
    while (!done5 && n < 60) begin
      if (poke >= 0) start = (n == poke);
      @(negedge clk);
      n++;
    end
    if (poke >= 0) start = 1'b0;
  endtask

  task automatic check_results(input string tag, input bit e_eq, input int c5_i,
                               input int c2_i, input int fm, input int n);
    int e_lat, e_stim, c5, c2;
    bit e_fv;
    e_fv = !e_eq;
    e_lat = 16; e_stim = 15; c5 = c5_i; c2 = c2_i;
`ifdef EQV_STOP_FIRST_EN
    if (e_fv) begin e_lat = fm + 1; e_stim = fm; c5 = 1; c2 = 1; end
`endif
    check($sformatf("%s.latency", tag), n, e_lat);
    check($sformatf("%s.done", tag), done5, 1);
    check($sformatf("%s.busy", tag), busy5, 0);
    check($sformatf("%s.equiv", tag), equiv5, e_eq);
    check($sformatf("%s.mism_cnt", tag), cnt5, c5);
    check($sformatf("%s.first_valid", tag), fv5, e_fv);
    check($sformatf("%s.first_mism", tag), fm5, e_fv ? fm : 0);
    check($sformatf("%s.stim", tag), if5.stim, e_stim);
    check($sformatf("%s.done_w2", tag), done2, 1);
    check($sformatf("%s.equiv_w2", tag), equiv2, e_eq);
    check($sformatf("%s.mism_cnt_w2", tag), cnt2, c2);
    check($sformatf("%s.first_mism_w2", tag), fm2, e_fv ? fm : 0);
  endtask

  task automatic run_expect(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input bit e_eq, input int c5, input int c2, input int fm,
                            input int poke);
    int n;
    ta = a; tb_t = b;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check($sformatf("%s.busy_at_start", tag), {busy5, done5, if5.stim}, {1'b1, 1'b0, 4'h0});
    wait_done(poke, n);
    check_results(tag, e_eq, c5, c2, fm, n);
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s.stim", tag), if5.stim, 0);
    check($sformatf("%s.flags", tag), {busy5, done5, equiv5, fv5}, 4'b0000);
    check($sformatf("%s.mism_cnt", tag), cnt5, 0);
    check($sformatf("%s.first_mism", tag), fm5, 0);
    check($sformatf("%s.w2", tag), {busy2, done2, equiv2, fv2, cnt2, fm2}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pop, first, c5, c2;
    logic [15:0] ra, rb;

    vecs[0] = '{EQ_TT, EQ_TT,            1'b1, 0,  0, 0};
    vecs[1] = '{EQ_TT, FAULTY_TT,        1'b0, 4,  3, 0};
    vecs[2] = '{EQ_TT, ~EQ_TT,           1'b0, 16, 3, 0};
    vecs[3] = '{EQ_TT, EQ_TT ^ 16'h8000, 1'b0, 1,  1, 15};
    vecs[4] = '{16'h0020, 16'h0000,      1'b0, 1,  1, 5};
    vecs[5] = '{16'hFF00, 16'h0000,      1'b0, 8,  3, 8};

    #2;
    check_zero("reset");
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i])
      run_expect($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].eq,
                 vecs[i].cnt5, vecs[i].cnt2, vecs[i].fm, -1);

    // Reset in the middle of a run drops everything
    ta = EQ_TT; tb_t = FAULTY_TT;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrun_reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset_idle");
    run_expect("after_reset", EQ_TT, FAULTY_TT, 1'b0, 4, 3, 0, -1);

    // Start pulsed while busy is ignored
    run_expect("start_in_run", vecs[3].a, vecs[3].b, 1'b0, 1, 1, 15, 5);

    // Start held across DONE restarts back to back
    ta = EQ_TT; tb_t = FAULTY_TT;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    wait_done(-1, n);
    check_results("held_run1", 1'b0, 4, 3, 0, n);
    @(negedge clk);
    check("held_restart", {busy5, done5, fv5, cnt5, if5.stim}, {1'b1, 1'b0, 1'b0, 5'd0, 4'h0});
    start = 1'b0;
    wait_done(-1, n);
    check_results("held_run2", 1'b0, 4, 3, 0, n);

    // Random truth tables against a popcount/first-difference model
    for (int r = 0; r < 20; r++) begin
      ra = 16'($urandom);
      case (r % 4)
        0: rb = ra;
        1: rb = ra ^ 16'($urandom & $urandom & $urandom);
        2: rb = ra ^ (16'h1 << $urandom_range(15, 0));
        default: rb = 16'($urandom);
      endcase
      pop = 0; first = -1;
      for (int p = 0; p < 16; p++) begin
        if (ra[p] != rb[p]) begin
          pop++;
          if (first < 0) first = p;
        end
      end
      c5 = (pop > 31) ? 31 : pop;
      c2 = (pop > 3) ? 3 : pop;
      run_expect($sformatf("rand%0d", r), ra, rb, pop == 0, c5, c2,
                 (first < 0) ? 0 : first, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
